enigma_stream: RTL and testbench

Parametrised, handshaked Enigma cipher engine for the encode datapath. Accepts ASCII characters on a valid/ready input stream, steps an N-rotor stack with full double-step behaviour, and encodes letters through the codebase's `plugboardEncode`, `encode` (forward and reverse), `reflectorEncode`, `encodeASCII` and `decodeASCII` chain. Results are buffered in an output FIFO for a valid/ready consumer, such as the UART TX or hex display. Rotor types, ring settings, start positions and reflector type are loaded at run time.

---
 rtl/enigma_stream_if.sv | 12 +
 rtl/enigma_stream.sv | 198 +++++++++++++++++++
 tb/tb_enigma_stream.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/enigma_stream_if.sv
// Character stream bundle for enigma_stream: plaintext in, ciphertext out.
interface enigma_stream_if;
  logic       i_valid;
  logic [7:0] i_data;
  logic       o_ready;
  logic       o_valid;
  logic [7:0] o_data;
  logic       i_out_ready;

  modport master (output i_valid, i_data, i_out_ready, input o_ready, o_valid, o_data);
  modport slave  (input i_valid, i_data, i_out_ready, output o_ready, o_valid, o_data);
endinterface

// File: rtl/enigma_stream.sv
// Handshaked N-rotor Enigma encoder with double-step stepping and an output FWFT FIFO.
// Config (types, rings, start positions, reflector) is loaded at run time while idle.
module enigma_stream #(
  parameter int unsigned NUM_ROTORS    = 3,
  parameter int unsigned FIFO_DEPTH    = 4,
  parameter bit          PASS_NONALPHA = 1'b1
) (
  input  logic                    i_clock,
  input  logic                    reset,
  input  logic                    i_cfg_load,
  input  logic [3*NUM_ROTORS-1:0] i_cfg_type,
  input  logic [5*NUM_ROTORS-1:0] i_cfg_start,
  input  logic [5*NUM_ROTORS-1:0] i_cfg_ring,
  input  logic                    i_cfg_reflector,
  output logic                    o_cfg_ready,
  enigma_stream_if.slave          bus,
  output logic [5*NUM_ROTORS-1:0] o_rotor_pos,
  output logic [15:0]             o_char_count
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);

  localparam logic [207:0] WireI   = "EKMFLGDQVZNTOWYHXUSPAIBRCJ";
  localparam logic [207:0] WireII  = "AJDKSIRUXBLHWTMCQGZNPYFVOE";
  localparam logic [207:0] WireIII = "BDFHJLCPRTXVZNYEIWGAKMQOUS";
  localparam logic [207:0] WireIV  = "ESOVPZJAYQUIRHXLNFTGKDCMWB";
  localparam logic [207:0] WireV   = "VZBRGITYUPSDNHLXAWMFCQOKJE";
  localparam logic [207:0] RefB    = "YRUHQSLDPXNGOKMIEBFZCWVJAT";
  localparam logic [207:0] RefC    = "FVPJIAOYEDRZXWGCTKUQSBNMHL";

  typedef enum logic [1:0] {StIdle, StStep, StEncode, StPass} state_e;

  function automatic logic [4:0] add26(input logic [4:0] a, input logic [4:0] b);
    logic [5:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (s >= 6'd26) ? 5'(s - 6'd26) : s[4:0];
  endfunction

  function automatic logic [4:0] sub26(input logic [4:0] a, input logic [4:0] b);
    return (a >= b) ? 5'(a - b) : 5'({1'b0, a} + 6'd26 - {1'b0, b});
  endfunction

  // First character of a table string sits in the top byte.
  function automatic logic [4:0] table_map(input logic [207:0] w, input logic [4:0] idx);
    logic [7:0] ch;
    ch = w[8*(25-int'(idx)) +: 8];
    return 5'(ch - 8'h41);
  endfunction

  function automatic logic [4:0] rotor_fwd(input logic [2:0] t, input logic [4:0] idx);
    case (t)
      3'd1:    return table_map(WireII, idx);
      3'd2:    return table_map(WireIII, idx);
      3'd3:    return table_map(WireIV, idx);
      3'd4:    return table_map(WireV, idx);
      default: return table_map(WireI, idx);
    endcase
  endfunction

  function automatic logic [4:0] rotor_inv(input logic [2:0] t, input logic [4:0] y);
    logic [4:0] r;
    r = '0;
    for (int j = 0; j < 26; j++) begin
      if (rotor_fwd(t, 5'(j)) == y) r = 5'(j);
    end
    return r;
  endfunction

  function automatic logic [4:0] notch(input logic [2:0] t);
    case (t)
      3'd1:    return 5'd4;
      3'd2:    return 5'd21;
      3'd3:    return 5'd9;
      3'd4:    return 5'd25;
      default: return 5'd16;
    endcase
  endfunction

  function automatic logic is_letter(input logic [7:0] d);
    return (d >= 8'h41 && d <= 8'h5A) || (d >= 8'h61 && d <= 8'h7A);
  endfunction

  function automatic logic [4:0] letter_code(input logic [7:0] d);
    return (d <= 8'h5A) ? 5'(d - 8'h41) : 5'(d - 8'h61);
  endfunction

  function automatic logic [NUM_ROTORS-1:0][2:0] default_types();
    logic [NUM_ROTORS-1:0][2:0] t;
    t    = '0;
    t[0] = 3'd2;
    t[1] = 3'd1;
    return t;
  endfunction

  state_e                     state_q;
  logic [NUM_ROTORS-1:0][4:0] pos_q, ring_q, pos_step;
  logic [NUM_ROTORS-1:0][2:0] type_q;
  logic                       refl_q;
  logic [15:0]                count_q;
  logic [7:0]                 data_q;
  logic [7:0]                 enc_ascii;
  logic [7:0]                 mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]            wr_q, rd_q;
  logic [PtrW:0]              fill_q;
  logic                       full, push, pop, cfg_accept, in_accept;
  logic [7:0]                 push_data;

  // Notch tests all look at pre-step positions, giving the middle-rotor double step.
  always_comb begin
    pos_step    = pos_q;
    pos_step[0] = add26(pos_q[0], 5'd1);
    for (int k = 1; k < int'(NUM_ROTORS); k++) begin
      if (pos_q[k-1] == notch(type_q[k-1]) ||
          (k < int'(NUM_ROTORS) - 1 && pos_q[k] == notch(type_q[k]))) begin
        pos_step[k] = add26(pos_q[k], 5'd1);
      end
    end
  end

  // Plugboard is the identity; signal runs right-to-left, reflects, then returns.
  always_comb begin : enc_path
    logic [NUM_ROTORS-1:0][4:0] shift;
    logic [4:0]                 x;
    shift = '0;
    x     = letter_code(data_q);
    for (int k = 0; k < int'(NUM_ROTORS); k++) begin
      shift[k] = sub26(pos_q[k], ring_q[k]);
      x        = sub26(rotor_fwd(type_q[k], add26(x, shift[k])), shift[k]);
    end
    x = table_map(refl_q ? RefC : RefB, x);
    for (int k = int'(NUM_ROTORS) - 1; k >= 0; k--) begin
      x = sub26(rotor_inv(type_q[k], add26(x, shift[k])), shift[k]);
    end
    enc_ascii = 8'h41 + {3'b000, x};
  end

  assign full        = (fill_q == (PtrW+1)'(FIFO_DEPTH));
  assign o_cfg_ready = (state_q == StIdle);
  assign bus.o_ready = (state_q == StIdle) && !full && !i_cfg_load;
  assign cfg_accept  = i_cfg_load && o_cfg_ready;
  assign in_accept   = bus.i_valid && bus.o_ready;
  assign push        = (state_q == StEncode) || ((state_q == StPass) && PASS_NONALPHA);
  assign push_data   = (state_q == StEncode) ? enc_ascii : data_q;
  assign pop         = (fill_q != '0) && bus.i_out_ready;
  assign bus.o_valid = (fill_q != '0);
  assign bus.o_data  = mem_q[rd_q];
  assign o_rotor_pos  = pos_q;
  assign o_char_count = count_q;

  always_ff @(posedge i_clock) begin
    if (reset) begin
      state_q <= StIdle;
      pos_q   <= '0;
      ring_q  <= '0;
      type_q  <= default_types();
      refl_q  <= 1'b0;
      count_q <= '0;
      data_q  <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      fill_q  <= '0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) mem_q[i] <= '0;
    end else begin
      if (push) begin
        mem_q[wr_q] <= push_data;
        wr_q        <= wr_q + 1'b1;
      end
      if (pop) rd_q <= rd_q + 1'b1;
      if (push && !pop)      fill_q <= fill_q + 1'b1;
      else if (!push && pop) fill_q <= fill_q - 1'b1;

      unique case (state_q)
        StIdle: begin
          if (cfg_accept) begin
            pos_q   <= i_cfg_start;
            type_q  <= i_cfg_type;
            ring_q  <= i_cfg_ring;
            refl_q  <= i_cfg_reflector;
            count_q <= '0;
          end else if (in_accept) begin
            data_q  <= bus.i_data;
            state_q <= is_letter(bus.i_data) ? StStep : StPass;
          end
        end
        StStep: begin
          pos_q   <= pos_step;
          state_q <= StEncode;
        end
        StEncode: begin
          count_q <= count_q + 16'd1;
          state_q <= StIdle;
        end
        StPass: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_enigma_stream.sv
// Directed bench for enigma_stream: known ciphertext, double step, pass/drop,
// backpressure, config load timing and mid-flight reset.
module tb_enigma_stream;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_load = 1'b0;
  logic [8:0]  cfg_type = '0;
  logic [14:0] cfg_start = '0;
  logic [14:0] cfg_ring = '0;
  logic        cfg_refl = 1'b0;
  logic        cfg_ready, cfg_ready_np;
  logic [14:0] rotor_pos, rotor_pos_np;
  logic [15:0] char_count, char_count_np;
  logic [7:0]  rx_q [$];
  logic [7:0]  rx_np [$];
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  enigma_stream_if bus ();
  enigma_stream_if bus_np ();

  enigma_stream dut (
    .i_clock(clk), .reset(rst), .i_cfg_load(cfg_load), .i_cfg_type(cfg_type),
    .i_cfg_start(cfg_start), .i_cfg_ring(cfg_ring), .i_cfg_reflector(cfg_refl),
    .o_cfg_ready(cfg_ready), .bus(bus), .o_rotor_pos(rotor_pos), .o_char_count(char_count)
  );

  enigma_stream #(.PASS_NONALPHA(1'b0)) dut_np (
    .i_clock(clk), .reset(rst), .i_cfg_load(1'b0), .i_cfg_type(cfg_type),
    .i_cfg_start(cfg_start), .i_cfg_ring(cfg_ring), .i_cfg_reflector(cfg_refl),
    .o_cfg_ready(cfg_ready_np), .bus(bus_np), .o_rotor_pos(rotor_pos_np),
    .o_char_count(char_count_np)
  );

  always @(negedge clk) begin
    if (!rst && bus.o_valid && bus.i_out_ready) rx_q.push_back(bus.o_data);
    if (!rst && bus_np.o_valid && bus_np.i_out_ready) rx_np.push_back(bus_np.o_data);
  end

  task automatic do_reset();
    rst = 1'b1;
    bus.i_valid = 1'b0;
    bus_np.i_valid = 1'b0;
    cfg_load = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    rx_q.delete();
    rx_np.delete();
  endtask

  task automatic send(input logic [7:0] c, input bit np);
    int n;
    n = 0;
    if (np) begin bus_np.i_valid = 1'b1; bus_np.i_data = c; end
    else begin bus.i_valid = 1'b1; bus.i_data = c; end
    @(negedge clk);
    while (!(np ? bus_np.o_ready : bus.o_ready) && n < 200) begin @(negedge clk); n++; end
    if (!(np ? bus_np.o_ready : bus.o_ready)) begin
      bad++; $display("FAIL send_timeout char=%h accepted=0 want=1", c);
    end
    @(posedge clk); #1;
    bus.i_valid = 1'b0;
    bus_np.i_valid = 1'b0;
  endtask

  task automatic wait_rx(input int n, input bit np);
    int k;
    k = 0;
    while ((np ? rx_np.size() : rx_q.size()) < n && k < 300) begin @(negedge clk); k++; end
    if ((np ? rx_np.size() : rx_q.size()) < n) begin
      bad++; $display("FAIL rx_timeout got=%0d want=%0d", np ? rx_np.size() : rx_q.size(), n);
    end
    @(posedge clk); #1;
  endtask

  task automatic load_cfg(input logic [8:0] t, input logic [14:0] s);
    int n;
    n = 0;
    cfg_type = t; cfg_start = s; cfg_ring = '0; cfg_refl = 1'b0; cfg_load = 1'b1;
    @(negedge clk);
    while (!cfg_ready && n < 50) begin @(negedge clk); n++; end
    if (!cfg_ready) begin bad++; $display("FAIL load_timeout cfg_ready=0 want=1"); end
    @(posedge clk); #1 cfg_load = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    total++; if (bus.o_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b want=0", bus.o_valid); end
    total++; if (bus.o_data !== 8'h00) begin bad++; $display("FAIL rst_data got=%h want=00", bus.o_data); end
    total++; if (cfg_ready !== 1'b1) begin bad++; $display("FAIL rst_cfg_ready got=%b want=1", cfg_ready); end
    total++; if (bus.o_ready !== 1'b1) begin bad++; $display("FAIL rst_ready got=%b want=1", bus.o_ready); end
    total++; if (rotor_pos !== 15'd0) begin bad++; $display("FAIL rst_pos got=%h want=0", rotor_pos); end
    total++; if (char_count !== 16'd0) begin bad++; $display("FAIL rst_count got=%0d want=0", char_count); end
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    string exp;
    exp = "BDZGO";
    do_reset();
    for (int i = 0; i < 5; i++) send(8'h41, 1'b0);
    wait_rx(5, 1'b0);
    for (int i = 0; i < 5; i++) begin
      total++;
      if (rx_q[i] !== exp[i]) begin bad++; $display("FAIL basic_char%0d got=%h want=%h", i, rx_q[i], exp[i]); end
    end
    @(negedge clk);
    total++; if (rotor_pos !== 15'd5) begin bad++; $display("FAIL basic_pos got=%h want=5", rotor_pos); end
    total++; if (char_count !== 16'd5) begin bad++; $display("FAIL basic_count got=%0d want=5", char_count); end
    @(posedge clk); #1;
  endtask

  task automatic test_latency();
    do_reset();
    bus.i_out_ready = 1'b0;
    send(8'h41, 1'b0);
    @(negedge clk);
    total++; if (rotor_pos !== 15'd0) begin bad++; $display("FAIL lat_pos_t1 got=%h want=0", rotor_pos); end
    @(negedge clk);
    total++; if (rotor_pos !== 15'd1) begin bad++; $display("FAIL lat_pos_t2 got=%h want=1", rotor_pos); end
    total++; if (bus.o_valid !== 1'b0) begin bad++; $display("FAIL lat_valid_t2 got=%b want=0", bus.o_valid); end
    @(negedge clk);
    total++; if (bus.o_valid !== 1'b1) begin bad++; $display("FAIL lat_valid_t3 got=%b want=1", bus.o_valid); end
    total++; if (bus.o_data !== 8'h42) begin bad++; $display("FAIL lat_data got=%h want=42", bus.o_data); end
    total++; if (char_count !== 16'd1) begin bad++; $display("FAIL lat_count got=%0d want=1", char_count); end
    @(posedge clk); #1 bus.i_out_ready = 1'b1;
  endtask

  task automatic test_double_step();
    logic [14:0] exp_pos [3];
    exp_pos = '{{5'd0, 5'd3, 5'd21}, {5'd0, 5'd4, 5'd22}, {5'd1, 5'd5, 5'd23}};
    do_reset();
    load_cfg({3'd0, 3'd1, 3'd2}, {5'd0, 5'd3, 5'd20});
    @(negedge clk);
    total++; if (rotor_pos !== {5'd0, 5'd3, 5'd20}) begin bad++; $display("FAIL ds_load_pos got=%h want=%h", rotor_pos, {5'd0, 5'd3, 5'd20}); end
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      send(8'h41, 1'b0);
      @(negedge clk);
      @(negedge clk);
      total++;
      if (rotor_pos !== exp_pos[i]) begin bad++; $display("FAIL ds_pos%0d got=%h want=%h", i, rotor_pos, exp_pos[i]); end
      @(posedge clk); #1;
    end
    wait_rx(3, 1'b0);
    total++; if (char_count !== 16'd3) begin bad++; $display("FAIL ds_count got=%0d want=3", char_count); end
  endtask

  task automatic test_pass();
    string exp;
    exp = "B D";
    do_reset();
    send(8'h41, 1'b0); send(8'h20, 1'b0); send(8'h41, 1'b0);
    wait_rx(3, 1'b0);
    for (int i = 0; i < 3; i++) begin
      total++;
      if (rx_q[i] !== exp[i]) begin bad++; $display("FAIL pass_char%0d got=%h want=%h", i, rx_q[i], exp[i]); end
    end
    total++; if (rotor_pos !== 15'd2) begin bad++; $display("FAIL pass_pos got=%h want=2", rotor_pos); end
    total++; if (char_count !== 16'd2) begin bad++; $display("FAIL pass_count got=%0d want=2", char_count); end
    send(8'h41, 1'b1); send(8'h20, 1'b1); send(8'h41, 1'b1);
    wait_rx(2, 1'b1);
    repeat (10) @(posedge clk);
    #1;
    total++; if (rx_np.size() !== 2) begin bad++; $display("FAIL drop_size got=%0d want=2", rx_np.size()); end
    total++; if (rx_np[0] !== 8'h42) begin bad++; $display("FAIL drop_char0 got=%h want=42", rx_np[0]); end
    total++; if (rx_np[1] !== 8'h44) begin bad++; $display("FAIL drop_char1 got=%h want=44", rx_np[1]); end
    total++; if (rotor_pos_np !== 15'd2) begin bad++; $display("FAIL drop_pos got=%h want=2", rotor_pos_np); end
  endtask

  task automatic test_back_to_back();
    string exp;
    exp = "BDZGOW";
    do_reset();
    bus.i_out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(8'h61, 1'b0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    total++; if (bus.o_ready !== 1'b0) begin bad++; $display("FAIL bp_ready got=%b want=0", bus.o_ready); end
    total++; if (cfg_ready !== 1'b1) begin bad++; $display("FAIL bp_idle got=%b want=1", cfg_ready); end
    total++; if (bus.o_data !== 8'h42) begin bad++; $display("FAIL bp_head got=%h want=42", bus.o_data); end
    @(posedge clk); #1 bus.i_out_ready = 1'b1;
    send(8'h61, 1'b0); send(8'h41, 1'b0);
    wait_rx(6, 1'b0);
    for (int i = 0; i < 6; i++) begin
      total++;
      if (rx_q[i] !== exp[i]) begin bad++; $display("FAIL bp_char%0d got=%h want=%h", i, rx_q[i], exp[i]); end
    end
  endtask

  task automatic test_cfg_in_step();
    int n;
    n = 0;
    do_reset();
    bus.i_out_ready = 1'b0;
    send(8'h41, 1'b0);
    cfg_type = {3'd0, 3'd1, 3'd2}; cfg_start = {5'd7, 5'd8, 5'd9}; cfg_ring = '0;
    cfg_refl = 1'b0; cfg_load = 1'b1;
    @(negedge clk);
    total++; if (cfg_ready !== 1'b0) begin bad++; $display("FAIL ld_step_ready got=%b want=0", cfg_ready); end
    while (!cfg_ready && n < 20) begin @(negedge clk); n++; end
    total++; if (cfg_ready !== 1'b1) begin bad++; $display("FAIL ld_idle_ready got=%b want=1", cfg_ready); end
    total++; if (char_count !== 16'd1) begin bad++; $display("FAIL ld_pre_count got=%0d want=1", char_count); end
    total++; if (rotor_pos !== 15'd1) begin bad++; $display("FAIL ld_pre_pos got=%h want=1", rotor_pos); end
    total++; if (bus.o_ready !== 1'b0) begin bad++; $display("FAIL ld_blocks_ready got=%b want=0", bus.o_ready); end
    @(posedge clk); #1 cfg_load = 1'b0;
    @(negedge clk);
    total++; if (rotor_pos !== {5'd7, 5'd8, 5'd9}) begin bad++; $display("FAIL ld_pos got=%h want=%h", rotor_pos, {5'd7, 5'd8, 5'd9}); end
    total++; if (char_count !== 16'd0) begin bad++; $display("FAIL ld_count got=%0d want=0", char_count); end
    total++; if (bus.o_data !== 8'h42 || bus.o_valid !== 1'b1) begin bad++; $display("FAIL ld_fifo_kept got=%b/%h want=1/42", bus.o_valid, bus.o_data); end
    @(posedge clk); #1 bus.i_out_ready = 1'b1;
  endtask

  task automatic test_reset_mid();
    do_reset();
    send(8'h41, 1'b0);
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    total++; if (rotor_pos !== 15'd1) begin bad++; $display("FAIL rm_stepped got=%h want=1", rotor_pos); end
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    total++; if (bus.o_valid !== 1'b0) begin bad++; $display("FAIL rm_valid got=%b want=0", bus.o_valid); end
    total++; if (rotor_pos !== 15'd0) begin bad++; $display("FAIL rm_pos got=%h want=0", rotor_pos); end
    @(posedge clk); #1;
    rx_q.delete();
    send(8'h61, 1'b0);
    wait_rx(1, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    total++; if (rx_q.size() !== 1) begin bad++; $display("FAIL rm_size got=%0d want=1", rx_q.size()); end
    total++; if (rx_q[0] !== 8'h42) begin bad++; $display("FAIL rm_char got=%h want=42", rx_q[0]); end
  endtask

  initial begin
    bus.i_valid = 1'b0; bus.i_data = '0; bus.i_out_ready = 1'b1;
    bus_np.i_valid = 1'b0; bus_np.i_data = '0; bus_np.i_out_ready = 1'b1;
    test_reset();
    test_basic();
    test_latency();
    test_double_step();
    test_pass();
    test_back_to_back();
    test_cfg_in_step();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
